wb_cmd_master: RTL

- Single-outstanding Wishbone pipelined-mode initiator.
- Converts a simple valid/ready command stream into one Wishbone cycle per command and returns a valid/ready response.
- Sits between a local sequencer or CPU-bridge and the bus-side register blocks, which act as slaves on its Wishbone port.
- Handles stall, ack, err, rty and an optional bus timeout.

---
 rtl/wb_cmd_master.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: single-outstanding Wishbone pipelined-mode initiator.
// Each accepted command becomes one Wishbone cycle. The master retries on
// rty until MAX_RETRY reissues have been used, and then returns one response.
// Optional feature: define WB_CMD_MASTER_TIMEOUT_EN to abort a cycle that
// gets no termination within TIMEOUT cycles of entering REQ.
module wb_cmd_master #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_RETRY  = 3,
   parameter int TIMEOUT    = 255
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    cmd_valid_i,
   output logic                    cmd_ready_o,
   input  logic                    cmd_we_i,
   input  logic [ADDR_WIDTH-1:0]   cmd_adr_i,
   input  logic [DATA_WIDTH-1:0]   cmd_dat_i,
   input  logic [DATA_WIDTH/8-1:0] cmd_sel_i,
   output logic                    rsp_valid_o,
   input  logic                    rsp_ready_i,
   output logic [DATA_WIDTH-1:0]   rsp_dat_o,
   output logic                    rsp_err_o,
   output logic                    rsp_timeout_o,
   output logic                    wb_cyc_o,
   output logic                    wb_stb_o,
   output logic [ADDR_WIDTH-1:0]   wb_adr_o,
   output logic [DATA_WIDTH/8-1:0] wb_sel_o,
   output logic                    wb_we_o,
   output logic [DATA_WIDTH-1:0]   wb_dat_o,
   input  logic                    wb_ack_i,
   input  logic                    wb_err_i,
   input  logic                    wb_rty_i,
   input  logic                    wb_stall_i,
   input  logic [DATA_WIDTH-1:0]   wb_dat_i
);

   localparam int SEL_WIDTH = DATA_WIDTH / 8;
   localparam int RETRY_W   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      WAIT  = 3'd2,
      RETRY = 3'd3,
      RSP   = 3'd4
   } state_t;

   state_t                 state, state_nxt;
   logic                   cyc_nxt, stb_nxt, we_nxt;
   logic [ADDR_WIDTH-1:0]  adr_nxt;
   logic [SEL_WIDTH-1:0]   sel_nxt;
   logic [DATA_WIDTH-1:0]  dat_nxt;
   logic                   rsp_valid_nxt, rsp_err_nxt;
   logic [DATA_WIDTH-1:0]  rsp_dat_nxt;
   logic [RETRY_W-1:0]     retry_cnt, retry_nxt;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
   localparam int TMO_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LAST  = (TIMEOUT < 1) ? '0 : TMO_W'(TIMEOUT - 1);
   localparam logic [TMO_W-1:0] TMO_SATUR = '1;
   logic [TMO_W-1:0]       tmo_cnt, tmo_cnt_nxt;
   logic                   rsp_tmo_nxt;
   logic                   timeout_hit;

   // Abort on the edge that closes the TIMEOUT-th cycle spent in REQ/WAIT.
   assign timeout_hit = (tmo_cnt >= TMO_LAST);
`else
   assign rsp_timeout_o = 1'b0;
`endif

   assign cmd_ready_o = (state == IDLE);

   // State, bus and response registers; reset drops the bus cycle at once.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= IDLE;
         wb_cyc_o    <= 1'b0;
         wb_stb_o    <= 1'b0;
         wb_we_o     <= 1'b0;
         wb_adr_o    <= '0;
         wb_sel_o    <= '0;
         wb_dat_o    <= '0;
         rsp_valid_o <= 1'b0;
         rsp_err_o   <= 1'b0;
         rsp_dat_o   <= '0;
         retry_cnt   <= '0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
         tmo_cnt       <= '0;
         rsp_timeout_o <= 1'b0;
`endif
      end else begin
         state       <= state_nxt;
         wb_cyc_o    <= cyc_nxt;
         wb_stb_o    <= stb_nxt;
         wb_we_o     <= we_nxt;
         wb_adr_o    <= adr_nxt;
         wb_sel_o    <= sel_nxt;
         wb_dat_o    <= dat_nxt;
         rsp_valid_o <= rsp_valid_nxt;
         rsp_err_o   <= rsp_err_nxt;
         rsp_dat_o   <= rsp_dat_nxt;
         retry_cnt   <= retry_nxt;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
         tmo_cnt       <= tmo_cnt_nxt;
         rsp_timeout_o <= rsp_tmo_nxt;
`endif
      end
   end

   // Next-state logic; terminations resolve err > rty > ack (> timeout).
   always_comb begin
      state_nxt     = state;
      cyc_nxt       = wb_cyc_o;
      stb_nxt       = wb_stb_o;
      we_nxt        = wb_we_o;
      adr_nxt       = wb_adr_o;
      sel_nxt       = wb_sel_o;
      dat_nxt       = wb_dat_o;
      rsp_valid_nxt = rsp_valid_o;
      rsp_err_nxt   = rsp_err_o;
      rsp_dat_nxt   = rsp_dat_o;
      retry_nxt     = retry_cnt;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
      tmo_cnt_nxt   = tmo_cnt;
      rsp_tmo_nxt   = rsp_timeout_o;
`endif

      case (state)
         IDLE: begin
            if (cmd_valid_i) begin
               adr_nxt   = cmd_adr_i;
               sel_nxt   = cmd_sel_i;
               we_nxt    = cmd_we_i;
               dat_nxt   = cmd_dat_i;
               cyc_nxt   = 1'b1;
               stb_nxt   = 1'b1;
               retry_nxt = '0;
               state_nxt = REQ;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
               tmo_cnt_nxt = '0;
`endif
            end
         end

         REQ, WAIT: begin
            if ((state == REQ) && !wb_stall_i) begin
               stb_nxt   = 1'b0;
               state_nxt = WAIT;
            end
`ifdef WB_CMD_MASTER_TIMEOUT_EN
            if (tmo_cnt != TMO_SATUR) begin
               tmo_cnt_nxt = tmo_cnt + 1'b1;
            end
`endif
            if (wb_err_i) begin
               cyc_nxt       = 1'b0;
               stb_nxt       = 1'b0;
               rsp_valid_nxt = 1'b1;
               rsp_err_nxt   = 1'b1;
               rsp_dat_nxt   = '0;
               state_nxt     = RSP;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
               rsp_tmo_nxt   = 1'b0;
`endif
            end else if (wb_rty_i) begin
               cyc_nxt = 1'b0;
               stb_nxt = 1'b0;
               if (retry_cnt < RETRY_LIMIT) begin
                  retry_nxt = retry_cnt + 1'b1;
                  state_nxt = RETRY;
               end else begin
                  rsp_valid_nxt = 1'b1;
                  rsp_err_nxt   = 1'b1;
                  rsp_dat_nxt   = '0;
                  state_nxt     = RSP;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
                  rsp_tmo_nxt   = 1'b0;
`endif
               end
            end else if (wb_ack_i) begin
               cyc_nxt       = 1'b0;
               stb_nxt       = 1'b0;
               rsp_valid_nxt = 1'b1;
               rsp_err_nxt   = 1'b0;
               rsp_dat_nxt   = wb_we_o ? '0 : wb_dat_i;
               state_nxt     = RSP;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
               rsp_tmo_nxt   = 1'b0;
            end else if (timeout_hit) begin
               cyc_nxt       = 1'b0;
               stb_nxt       = 1'b0;
               rsp_valid_nxt = 1'b1;
               rsp_err_nxt   = 1'b1;
               rsp_dat_nxt   = '0;
               rsp_tmo_nxt   = 1'b1;
               state_nxt     = RSP;
`endif
            end
         end

         RETRY: begin
            cyc_nxt   = 1'b1;
            stb_nxt   = 1'b1;
            state_nxt = REQ;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
            tmo_cnt_nxt = '0;
`endif
         end

         RSP: begin
            if (rsp_ready_i) begin
               rsp_valid_nxt = 1'b0;
               state_nxt     = IDLE;
            end
         end

         default: begin
            cyc_nxt       = 1'b0;
            stb_nxt       = 1'b0;
            rsp_valid_nxt = 1'b0;
            state_nxt     = IDLE;
         end
      endcase
   end

endmodule
